// File: rtl/fp32_pipe_adder_if.sv
// rtl/fp32_pipe_adder_if.sv - operand/result bundle for the pipelined binary32 adder
interface fp32_pipe_adder_if #(
  parameter int STAGES = 5
);
  logic              inp_rdy;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [STAGES-1:0] data_status;
  logic [STAGES-1:0] stage_status;
  logic [31:0]       out_sum;

  modport master (
    output inp_rdy, in_a, in_b,
    input  data_status, stage_status, out_sum
  );

  modport slave (
    input  inp_rdy, in_a, in_b,
    output data_status, stage_status, out_sum
  );
endinterface

// File: rtl/fp32_pipe_adder.sv
// rtl/fp32_pipe_adder.sv - five-stage pipelined binary32 adder, no backpressure
// FP_ADD_ROUND_NEAREST_EN: round to nearest even; otherwise truncate and saturate on overflow.
module fp32_pipe_adder #(
  parameter int STAGES = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  fp32_pipe_adder_if.slave  bus
);

`ifdef FP_ADD_ROUND_NEAREST_EN
  localparam bit ROUND_NEAREST = 1'b1;
`else
  localparam bit ROUND_NEAREST = 1'b0;
`endif

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------- stage 1: unpack and classify ----------------
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        in_special;
  logic [31:0] in_spec_val;

  assign {sa, ea, fa} = bus.in_a;
  assign {sb, eb, fb} = bus.in_b;

  // Subnormals fall into the zero class and are flushed.
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign in_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  always_comb begin
    in_spec_val = 32'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) in_spec_val = QNAN;
    else if (a_inf)                                         in_spec_val = bus.in_a;
    else if (b_inf)                                         in_spec_val = bus.in_b;
    else if (a_zero && b_zero)                              in_spec_val = {sa & sb, 31'd0};
    else if (a_zero)                                        in_spec_val = bus.in_b;
    else if (b_zero)                                        in_spec_val = bus.in_a;
  end

  logic        s1_valid, s1_spec;
  logic [31:0] s1_spec_val;
  logic        s1_sa, s1_sb;
  logic [7:0]  s1_ea, s1_eb;
  logic [23:0] s1_ma, s1_mb;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid    <= 1'b0;
      s1_spec     <= 1'b0;
      s1_spec_val <= 32'd0;
      s1_sa       <= 1'b0;
      s1_sb       <= 1'b0;
      s1_ea       <= 8'd0;
      s1_eb       <= 8'd0;
      s1_ma       <= 24'd0;
      s1_mb       <= 24'd0;
    end else begin
      s1_valid    <= bus.inp_rdy;
      s1_spec     <= bus.inp_rdy & in_special;
      s1_spec_val <= in_spec_val;
      s1_sa       <= sa;
      s1_sb       <= sb;
      s1_ea       <= ea;
      s1_eb       <= eb;
      s1_ma       <= {1'b1, fa};
      s1_mb       <= {1'b1, fb};
    end
  end

  // ---------------- stage 2: swap and align ----------------
  logic        a_big;
  logic        big_s;
  logic [7:0]  big_e, sml_e, diff;
  logic [23:0] big_m, sml_m;
  logic [26:0] sml_ext, sml_shift, sml_align;
  logic        sml_lost;

  assign a_big   = (s1_ea > s1_eb) || ((s1_ea == s1_eb) && (s1_ma >= s1_mb));
  assign big_s   = a_big ? s1_sa : s1_sb;
  assign big_e   = a_big ? s1_ea : s1_eb;
  assign sml_e   = a_big ? s1_eb : s1_ea;
  assign big_m   = a_big ? s1_ma : s1_mb;
  assign sml_m   = a_big ? s1_mb : s1_ma;
  assign diff    = big_e - sml_e;
  assign sml_ext = {sml_m, 3'b000};

  // Bits shifted past the round position collapse into the sticky bit (bit 0).
  always_comb begin
    sml_shift = 27'd0;
    sml_lost  = 1'b0;
    if (diff >= 8'd27) begin
      sml_align = {26'd0, |sml_m};
    end else begin
      sml_shift = sml_ext >> diff[4:0];
      sml_lost  = |(sml_ext & ~(27'h7FF_FFFF << diff[4:0]));
      sml_align = {sml_shift[26:1], sml_shift[0] | sml_lost};
    end
  end

  logic        s2_valid, s2_spec;
  logic [31:0] s2_spec_val;
  logic        s2_sign, s2_sub;
  logic [7:0]  s2_exp;
  logic [26:0] s2_big, s2_sml;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s2_valid    <= 1'b0;
      s2_spec     <= 1'b0;
      s2_spec_val <= 32'd0;
      s2_sign     <= 1'b0;
      s2_sub      <= 1'b0;
      s2_exp      <= 8'd0;
      s2_big      <= 27'd0;
      s2_sml      <= 27'd0;
    end else begin
      s2_valid    <= s1_valid;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_sign     <= big_s;
      s2_sub      <= s1_sa ^ s1_sb;
      s2_exp      <= big_e;
      s2_big      <= {big_m, 3'b000};
      s2_sml      <= sml_align;
    end
  end

  // ---------------- stage 3: add / subtract ----------------
  logic [27:0] sum28;

  assign sum28 = s2_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                        : ({1'b0, s2_big} + {1'b0, s2_sml});

  logic        s3_valid, s3_spec;
  logic [31:0] s3_spec_val;
  logic        s3_sign;
  logic [7:0]  s3_exp;
  logic [27:0] s3_sum;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s3_valid    <= 1'b0;
      s3_spec     <= 1'b0;
      s3_spec_val <= 32'd0;
      s3_sign     <= 1'b0;
      s3_exp      <= 8'd0;
      s3_sum      <= 28'd0;
    end else begin
      s3_valid    <= s2_valid;
      s3_spec     <= s2_spec;
      s3_spec_val <= s2_spec_val;
      s3_sign     <= s2_sign;
      s3_exp      <= s2_exp;
      s3_sum      <= sum28;
    end
  end

  // ---------------- stage 4: normalize ----------------
  logic [4:0]        lz;
  logic [26:0]       norm_m;
  logic signed [9:0] norm_e;
  logic              norm_zero;

  assign lz        = lzc27(s3_sum[26:0]);
  assign norm_zero = (s3_sum == 28'd0);

  always_comb begin
    if (s3_sum[27]) begin
      norm_m = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
      norm_e = $signed({2'b00, s3_exp}) + 10'sd1;
    end else begin
      norm_m = s3_sum[26:0] << lz;
      norm_e = $signed({2'b00, s3_exp}) - $signed({5'b00000, lz});
    end
  end

  logic              s4_valid, s4_spec;
  logic [31:0]       s4_spec_val;
  logic              s4_sign, s4_zero;
  logic signed [9:0] s4_exp;
  logic [26:0]       s4_mant;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s4_valid    <= 1'b0;
      s4_spec     <= 1'b0;
      s4_spec_val <= 32'd0;
      s4_sign     <= 1'b0;
      s4_zero     <= 1'b0;
      s4_exp      <= 10'sd0;
      s4_mant     <= 27'd0;
    end else begin
      s4_valid    <= s3_valid;
      s4_spec     <= s3_spec;
      s4_spec_val <= s3_spec_val;
      s4_sign     <= s3_sign;
      s4_zero     <= norm_zero;
      s4_exp      <= norm_e;
      s4_mant     <= norm_m;
    end
  end

  // ---------------- stage 5: round and pack ----------------
  logic              rnd_up;
  logic [24:0]       rnd_m;
  logic [22:0]       fin_frac;
  logic signed [9:0] fin_e;
  logic [31:0]       result;

  assign rnd_up   = ROUND_NEAREST & s4_mant[2] & (s4_mant[1] | s4_mant[0] | s4_mant[3]);
  assign rnd_m    = {1'b0, s4_mant[26:3]} + {24'd0, rnd_up};
  assign fin_frac = rnd_m[24] ? rnd_m[23:1] : rnd_m[22:0];
  assign fin_e    = rnd_m[24] ? (s4_exp + 10'sd1) : s4_exp;

  always_comb begin
    if (s4_spec)                 result = s4_spec_val;
    else if (s4_zero)            result = 32'd0;
    else if (fin_e >= 10'sd255)  result = ROUND_NEAREST ? {s4_sign, 8'hFF, 23'd0}
                                                        : {s4_sign, 8'hFE, 23'h7F_FFFF};
    else if (fin_e <= 10'sd0)    result = {s4_sign, 31'd0};
    else                         result = {s4_sign, fin_e[7:0], fin_frac};
  end

  logic        s5_valid, s5_spec;
  logic [31:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s5_valid <= 1'b0;
      s5_spec  <= 1'b0;
      sum_q    <= 32'd0;
    end else begin
      s5_valid <= s4_valid;
      s5_spec  <= s4_spec;
      if (s4_valid) sum_q <= result;
    end
  end

  logic [STAGES-1:0] valid_vec, spec_vec;

  assign valid_vec        = {s5_valid, s4_valid, s3_valid, s2_valid, s1_valid};
  assign spec_vec         = {s5_spec, s4_spec, s3_spec, s2_spec, s1_spec};
  assign bus.data_status  = valid_vec;
  assign bus.stage_status = spec_vec;
  assign bus.out_sum      = sum_q;

endmodule

// File: tb/tb_fp32_pipe_adder.sv
// tb/tb_fp32_pipe_adder.sv - directed-vector scoreboard bench for fp32_pipe_adder
module tb_fp32_pipe_adder;

  typedef struct {
    logic [31:0] sum;
    int          cyc;
    logic        spec;
  } exp_t;

`ifdef FP_ADD_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_RND_UP = 32'h3F80_0001;
  localparam logic [31:0] EXP_OVF    = 32'h7F80_0000;
`else
  localparam logic [31:0] EXP_RND_UP = 32'h3F80_0000;
  localparam logic [31:0] EXP_OVF    = 32'h7F7F_FFFF;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] last_sum = 32'd0;
  exp_t sb[$];

  fp32_pipe_adder_if bus ();

  fp32_pipe_adder dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_sum, input logic exp_spec);
    exp_t e;
    @(negedge clk);
    bus.inp_rdy = 1'b1;
    bus.in_a    = a;
    bus.in_b    = b;
    e.sum  = exp_sum;
    e.cyc  = cyc + 1;
    e.spec = exp_spec;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.inp_rdy = 1'b0;
      bus.in_a    = 32'd0;
      bus.in_b    = 32'd0;
    end
  endtask

  // Monitor: pops one expectation per valid result; holds out_sum steady otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_sum = 32'd0;
      end else if (bus.data_status[4]) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got out_sum %h with no pending operation", bus.out_sum);
        end else begin
          e = sb.pop_front();
          check("out_sum", bus.out_sum, e.sum);
          check("latency", 32'(cyc), 32'(e.cyc + 4));
          check("special_flag", {31'd0, bus.stage_status[4]}, {31'd0, e.spec});
          last_sum = e.sum;
        end
      end else begin
        check("hold", bus.out_sum, last_sum);
      end
    end
  end

  initial begin
    bus.inp_rdy = 1'b0;
    bus.in_a    = 32'd0;
    bus.in_b    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", bus.out_sum, 32'd0);
    check("reset_data_status", {27'd0, bus.data_status}, 32'd0);
    check("reset_stage_status", {27'd0, bus.stage_status}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    issue(32'hBECC_CCCD, 32'h3E99_999A, 32'hBDCC_CCCC, 1'b0);
    idle(8);

    issue(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    issue(32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 1'b0);
    idle(8);

    issue(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0);
    issue(32'h3F80_0000, 32'h33C0_0000, EXP_RND_UP, 1'b0);
    idle(8);

    // Inf - Inf travels alone so its special flag can be followed stage by stage.
    issue(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1);
    @(posedge clk);
    #1;
    bus.inp_rdy = 1'b0;
    check("stage_status_s1", {27'd0, bus.stage_status}, 32'd1);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("stage_status_travel", {27'd0, bus.stage_status}, 32'd1 << k);
    end
    idle(4);

    issue(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1);
    issue(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0);
    issue(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b1);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, EXP_OVF, 1'b0);
    issue(32'h0080_0000, 32'h8000_0000, 32'h0080_0000, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    idle(8);

    // Three pairs in flight, then an asynchronous reset between clock edges.
    issue(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
    issue(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0);
    @(posedge clk);
    #2;
    bus.inp_rdy = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_sum", bus.out_sum, 32'd0);
    check("async_reset_data_status", {27'd0, bus.data_status}, 32'd0);
    check("async_reset_stage_status", {27'd0, bus.stage_status}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    issue(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    idle(1);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp32_pipe_adder.md
Name: fp32_pipe_adder

Overview:
- Five-stage pipelined IEEE-754 single-precision adder: one addition accepted per clock, one result per clock after a fixed 5-cycle latency.
- Datapath building block for arithmetic units.
- No backpressure. Per-stage valid and special-case flags are exported for debug and for downstream result qualification.

Parameters:
- STAGES, 5, pipeline depth. Fixed; the status bus widths depend on it.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- inp_rdy  in  1  input valid. in_a/in_b are captured on each rising edge where this is 1.
- in_a  in  32  operand A (IEEE-754 binary32).
- in_b  in  32  operand B (IEEE-754 binary32).
- data_status  out  5  bit i = pipeline stage i+1 holds valid data; bit 4 = out_sum valid.
- stage_status  out  5  bit i = stage i+1 holds a special-case result (NaN, Inf or zero operand) that bypasses the arithmetic.
- out_sum  out  32  result register.

Behaviour:
- Reset (rst_i=0, asynchronous): every pipeline register, data_status, stage_status and out_sum is cleared to 0. Reset asserted mid-operation discards all in-flight data.
- Stage 1: register the operands; unpack sign, exponent and mantissa with the hidden bit; classify each operand as zero, inf, NaN or normal. Subnormal inputs are flushed to zero. The valid bit for stage 1 is inp_rdy.
- Stage 2: swap so the larger magnitude is first (compare exponent, then mantissa). Right-align the smaller mantissa by the exponent difference, keeping guard, round and sticky bits; for a shift of 27 or more, only the sticky bit remains. The effective operation is the XOR of the two signs.
- Stage 3: 28-bit mantissa add or subtract. The result sign is the sign of the larger-magnitude operand.
- Stage 4: normalize.
  - Carry out: shift right by 1, exponent +1, sticky keeps the lost bit.
  - Otherwise: leading-zero count, shift left, subtract the count from the exponent.
- Stage 5: round, pack and write out_sum.
  - Round to nearest, ties to even. Mantissa overflow after rounding renormalizes.
  - Exponent ≥ 255 gives signed infinity (mantissa 0).
  - Exponent ≤ 0 flushes to signed zero.
- Special cases, resolved in stage 1 and carried along with the stage_status bit set:
  - Any NaN input, or +Inf + -Inf, gives 0x7FC00000.
  - Inf + finite gives that Inf.
  - Zero + x gives x (normalized x).
  - +0 + -0 gives +0; -0 + -0 gives -0.
  - An exact cancellation result is +0.
- Latency: operands captured at edge N appear on out_sum after edge N+4, with data_status[4]=1 for that same cycle. Throughput is 1 per cycle.
- Bubbles: when inp_rdy=0, a zero valid bit propagates. out_sum holds its last valid value and only updates when the stage 5 valid bit is 1. data_status[4] falls to 0 during bubbles.
- Valid and flag bits shift one stage per clock, unconditionally. There is no stall.

Optional Feature:
- Macro FP_ADD_ROUND_NEAREST_EN.
- When defined: round to nearest, ties to even, as above.
- When undefined: truncation (round toward zero). Guard, round and sticky are computed but ignored, and overflow gives the largest finite value of the matching sign (0x7F7FFFFF or 0xFF7FFFFF) instead of Inf.
- All Test Plan values assume the macro is defined.

Test Plan:
- Reset, release, then in_a=0xBECCCCCD (-0.4), in_b=0x3E99999A (0.3), inp_rdy=1 for one cycle -> out_sum=0xBDCCCCCC, data_status[4] pulses for exactly one cycle 5 edges after capture; data_status=0 and out_sum=0 before that.
- Back-to-back: (0x3F800000+0x3F800000), then (0x40000000+0x3F800000) on consecutive cycles -> 0x40000000 then 0x40400000 on consecutive cycles; then out_sum holds 0x40400000 while data_status[4]=0.
- Rounding: 0x3F800000+0x33800000 (tie) -> 0x3F800000; 0x3F800000+0x33C00000 -> 0x3F800001.
- Specials: 0x7F800000+0xFF800000 -> 0x7FC00000 with stage_status bits set as it travels; 0x7FC00001+0x3F800000 -> 0x7FC00000; 0x3F800000+0xBF800000 -> 0x00000000.
- Overflow: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000; 0x00800000+0x80000000 -> 0x00800000.
- Reset mid-flight: issue 3 valid operand pairs, pull rst_i low asynchronously between edges -> outputs read 0 immediately; after release no stale result appears.
